imem_loadable: RTL and testbench



---
 rtl/imem_loadable.sv | 231 +++++++++++++++++++++++
 tb/tb_imem_loadable.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
// Synchronous instruction memory for the MIPS core. Fetch is a registered
// 1-cycle read with a valid flag. The array is loaded at runtime from a byte
// stream (big-endian within each word), so new programs need no resynthesis.
//
// Parameters : DATA_W (multiple of 8), ADDR_W (word address width),
//              DEPTH (words, DEPTH <= 2**ADDR_W)
// Ports      : clk, rst_n (async, active-low)
//              fetch_req, fetch_addr -> fetch_valid, fetch_data (latency 1)
//              load_start, load_byte_valid, load_byte, load_done (stream in)
//              loading, load_count, load_overflow (load status)
//              fetch_perr (only with IMEM_PARITY_EN)
// Options    : define IMEM_PARITY_EN to store an even-parity bit per word and
//              flag mismatches on fetch through fetch_perr.
// -----------------------------------------------------------------------------
module imem_loadable #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_start,
    input  logic              load_byte_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_done,
    output logic              loading,
    output logic [ADDR_W:0]   load_count,
    output logic              load_overflow
`ifdef IMEM_PARITY_EN
    ,
    output logic              fetch_perr
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity_f(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    logic [MEM_W-1:0]  mem_r [0:DEPTH-1];
    state_t            state_r;
    logic [BCW-1:0]    byte_cnt_r;
    logic [DATA_W-1:0] word_r;
    logic [ADDR_W:0]   load_count_r;   // doubles as the write pointer
    logic              overflow_r;
    logic              loading_r;
    logic              fetch_valid_r;
    logic [DATA_W-1:0] fetch_data_r;

    logic              full_s;
    logic              accept_s;
    logic              last_s;
    logic [BCW-1:0]    cnt_after_s;
    logic [DATA_W-1:0] asm_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;

    assign fetch_valid   = fetch_valid_r;
    assign fetch_data    = fetch_data_r;
    assign loading       = loading_r;
    assign load_count    = load_count_r;
    assign load_overflow = overflow_r;

    // Byte acceptance, word assembly and write-port selection.
    always_comb begin
        full_s   = (load_count_r == DEPTH_L);
        // A simultaneous load_start restarts the load and drops the byte.
        accept_s = (state_r == ST_LOAD) && !load_start && load_byte_valid && !full_s;
        last_s   = (byte_cnt_r == LAST_BYTE);
        asm_s    = word_r;
        for (int b = 0; b < BYTES; b++) begin
            if (byte_cnt_r == BCW'(b)) begin
                asm_s[DATA_W-1-8*b -: 8] = load_byte;
            end else begin
                asm_s[DATA_W-1-8*b -: 8] = word_r[DATA_W-1-8*b -: 8];
            end
        end
        if (accept_s && last_s) begin
            cnt_after_s = {BCW{1'b0}};
        end else if (accept_s) begin
            cnt_after_s = byte_cnt_r + BCW'(1);
        end else begin
            cnt_after_s = byte_cnt_r;
        end
        // Pointer is below DEPTH whenever a write happens, so the low bits suffice.
        waddr_s = load_count_r[ADDR_W-1:0];
        if (accept_s && last_s) begin
            we_s    = 1'b1;
            wdata_s = asm_s;
        end else if (state_r == ST_FLUSH) begin
            we_s    = 1'b1;
            wdata_s = word_r;   // unfilled low bytes are already zero
        end else begin
            we_s    = 1'b0;
            wdata_s = word_r;
        end
    end

    // Memory write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
`ifdef IMEM_PARITY_EN
            mem_r[waddr_s] <= {parity_f(wdata_s), wdata_s};
`else
            mem_r[waddr_s] <= wdata_s;
`endif
        end
    end

    // Load control state machine with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            byte_cnt_r   <= {BCW{1'b0}};
            word_r       <= {DATA_W{1'b0}};
            load_count_r <= {(ADDR_W+1){1'b0}};
            overflow_r   <= 1'b0;
            loading_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (load_start) begin
                        state_r      <= ST_LOAD;
                        loading_r    <= 1'b1;
                        byte_cnt_r   <= {BCW{1'b0}};
                        word_r       <= {DATA_W{1'b0}};
                        load_count_r <= {(ADDR_W+1){1'b0}};
                        overflow_r   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        byte_cnt_r   <= {BCW{1'b0}};
                        word_r       <= {DATA_W{1'b0}};
                        load_count_r <= {(ADDR_W+1){1'b0}};
                        overflow_r   <= 1'b0;
                    end else begin
                        if (load_byte_valid && full_s) begin
                            overflow_r <= 1'b1;
                        end
                        if (accept_s && last_s) begin
                            word_r       <= {DATA_W{1'b0}};
                            load_count_r <= load_count_r + (ADDR_W + 1)'(1);
                        end else if (accept_s) begin
                            word_r <= asm_s;
                        end
                        byte_cnt_r <= cnt_after_s;
                        // Done rule sees the byte accepted in this same cycle.
                        if (load_done) begin
                            if (cnt_after_s != {BCW{1'b0}}) begin
                                state_r <= ST_FLUSH;
                            end else begin
                                state_r   <= ST_RUN;
                                loading_r <= 1'b0;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    load_count_r <= load_count_r + (ADDR_W + 1)'(1);
                    word_r       <= {DATA_W{1'b0}};
                    byte_cnt_r   <= {BCW{1'b0}};
                    state_r      <= ST_RUN;
                    loading_r    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_RUN;
                    loading_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_PARITY_EN
    logic fetch_perr_r;
    assign fetch_perr = fetch_perr_r;
`endif

    // Registered fetch port; served only in RUN, data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_r <= 1'b0;
            fetch_data_r  <= {DATA_W{1'b0}};
`ifdef IMEM_PARITY_EN
            fetch_perr_r  <= 1'b0;
`endif
        end else if ((state_r == ST_RUN) && fetch_req) begin
            fetch_valid_r <= 1'b1;
            if ({1'b0, fetch_addr} < DEPTH_L) begin
                fetch_data_r <= mem_r[fetch_addr][DATA_W-1:0];
`ifdef IMEM_PARITY_EN
                fetch_perr_r <= parity_f(mem_r[fetch_addr][DATA_W-1:0]) != mem_r[fetch_addr][DATA_W];
`endif
            end else begin
                fetch_data_r <= {DATA_W{1'b0}};
`ifdef IMEM_PARITY_EN
                fetch_perr_r <= 1'b0;
`endif
            end
        end else begin
            fetch_valid_r <= 1'b0;
`ifdef IMEM_PARITY_EN
            fetch_perr_r  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          load_start;
    logic          load_byte_valid;
    logic [7:0]    load_byte;
    logic          load_done;
    logic          loading;
    logic [AW:0]   load_count;
    logic          load_overflow;
`ifdef IMEM_PARITY_EN
    logic          fetch_perr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    imem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_valid     (fetch_valid),
        .fetch_data      (fetch_data),
        .load_start      (load_start),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .load_done       (load_done),
        .loading         (loading),
        .load_count      (load_count),
        .load_overflow   (load_overflow)
`ifdef IMEM_PARITY_EN
        ,
        .fetch_perr      (fetch_perr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fr;
        logic [AW-1:0] fa;
        logic          ls;
        logic          bv;
        logic [7:0]    b;
        logic          ld;
        logic          ev;
        logic [DW-1:0] ed;
        logic          elg;
        logic [AW:0]   ecnt;
        logic          eov;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic fr, input logic [AW-1:0] fa, input logic ls,
                                input logic bv, input logic [7:0] b, input logic ld,
                                input logic ev, input logic [DW-1:0] ed, input logic elg,
                                input logic [AW:0] ecnt, input logic eov);
        vec_t v;
        v.fr = fr; v.fa = fa; v.ls = ls; v.bv = bv; v.b = b; v.ld = ld;
        v.ev = ev; v.ed = ed; v.elg = elg; v.ecnt = ecnt; v.eov = eov;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic ls,
                         input logic bv, input logic [7:0] b, input logic ld);
        fetch_req = fr; fetch_addr = fa; load_start = ls;
        load_byte_valid = bv; load_byte = b; load_done = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rbytes [0:9];
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);

        // ---- vector table: {inputs} -> {outputs after the edge} ----
        // program load: two full words
        add(0,0,1,0,8'h00,0, 0,32'h0,1,0,0);
        add(0,0,0,1,8'h28,0, 0,32'h0,1,0,0);
        add(0,0,0,1,8'h02,0, 0,32'h0,1,0,0);
        add(0,0,0,1,8'h00,0, 0,32'h0,1,0,0);
        add(0,0,0,1,8'h05,0, 0,32'h0,1,1,0);
        add(0,0,0,1,8'h28,0, 0,32'h0,1,1,0);
        add(0,0,0,1,8'h03,0, 0,32'h0,1,1,0);
        add(0,0,0,1,8'h00,0, 0,32'h0,1,1,0);
        add(0,0,0,1,8'h0c,0, 0,32'h0,1,2,0);
        add(0,0,0,0,8'h00,1, 0,32'h0,0,2,0);
        add(1,0,0,0,8'h00,0, 1,32'h28020005,0,2,0);
        add(1,1,0,0,8'h00,0, 1,32'h2803000c,0,2,0);
        add(0,0,0,0,8'h00,0, 0,32'h2803000c,0,2,0);
        // partial word -> FLUSH
        add(0,0,1,0,8'h00,0, 0,32'h2803000c,1,0,0);
        add(0,0,0,1,8'hAA,0, 0,32'h2803000c,1,0,0);
        add(0,0,0,1,8'hBB,0, 0,32'h2803000c,1,0,0);
        add(0,0,0,1,8'hCC,0, 0,32'h2803000c,1,0,0);
        add(0,0,0,1,8'hDD,0, 0,32'h2803000c,1,1,0);
        add(0,0,0,1,8'h11,0, 0,32'h2803000c,1,1,0);
        add(0,0,0,0,8'h00,1, 0,32'h2803000c,1,1,0);
        add(0,0,0,0,8'h00,0, 0,32'h2803000c,0,2,0);
        add(1,1,0,0,8'h00,0, 1,32'h11000000,0,2,0);
        add(1,0,0,0,8'h00,0, 1,32'hAABBCCDD,0,2,0);
        // overflow on DEPTH=4 with fetch_req held during LOAD
        add(0,0,1,0,8'h00,0, 0,32'hAABBCCDD,1,0,0);
        for (int k = 0; k < 20; k++) begin
            add(1,0,0,1,8'(k),0, 0,32'hAABBCCDD,1,
                (k >= 15) ? 4'd4 : 4'((k + 1) / 4), (k >= 16) ? 1'b1 : 1'b0);
        end
        add(0,0,0,0,8'h00,1, 0,32'hAABBCCDD,0,4,1);
        add(1,3,0,0,8'h00,0, 1,32'h0c0d0e0f,0,4,1);
        add(1,5,0,0,8'h00,0, 1,32'h00000000,0,4,1);
        add(1,0,0,0,8'h00,0, 1,32'h00010203,0,4,1);
        add(0,0,0,0,8'h00,0, 0,32'h00010203,0,4,1);
        // new load clears overflow; start beats a simultaneous byte
        add(0,0,1,0,8'h00,0, 0,32'h00010203,1,0,0);
        add(0,0,1,1,8'h77,0, 0,32'h00010203,1,0,0);
        add(0,0,0,1,8'h11,0, 0,32'h00010203,1,0,0);
        add(0,0,0,1,8'h22,0, 0,32'h00010203,1,0,0);
        add(0,0,0,1,8'h33,0, 0,32'h00010203,1,0,0);
        // last byte together with done: word completes, straight to RUN
        add(0,0,0,1,8'h44,1, 0,32'h00010203,0,1,0);
        add(1,0,0,0,8'h00,0, 1,32'h11223344,0,1,0);
        // start together with done: start wins
        add(0,0,1,0,8'h00,1, 0,32'h11223344,1,0,0);
        add(0,0,0,0,8'h00,1, 0,32'h11223344,0,0,0);
        add(1,1,0,0,8'h00,0, 1,32'h04050607,0,0,0);
        add(0,0,0,0,8'h00,0, 0,32'h04050607,0,0,0);

        // ---- reset state ----
        step(); step();
        check("rst_valid", 32'(fetch_valid), 32'h0);
        check("rst_data", fetch_data, 32'h0);
        check("rst_loading", 32'(loading), 32'h0);
        check("rst_count", 32'(load_count), 32'h0);
        check("rst_ovf", 32'(load_overflow), 32'h0);
`ifdef IMEM_PARITY_EN
        check("rst_perr", 32'(fetch_perr), 32'h0);
`endif
        rst_n = 1'b1;
        step();

        // ---- apply vector table ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fr, vecs[i].fa, vecs[i].ls, vecs[i].bv, vecs[i].b, vecs[i].ld);
            step();
            check($sformatf("v%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_data", i), fetch_data, vecs[i].ed);
            check($sformatf("v%0d_loading", i), 32'(loading), 32'(vecs[i].elg));
            check($sformatf("v%0d_count", i), 32'(load_count), 32'(vecs[i].ecnt));
            check($sformatf("v%0d_ovf", i), 32'(load_overflow), 32'(vecs[i].eov));
`ifdef IMEM_PARITY_EN
            check($sformatf("v%0d_perr", i), 32'(fetch_perr), 32'h0);
`endif
        end

        // ---- reset in the middle of the 3rd word ----
        rbytes[0] = 8'hde; rbytes[1] = 8'had; rbytes[2] = 8'hbe; rbytes[3] = 8'hef;
        rbytes[4] = 8'hca; rbytes[5] = 8'hfe; rbytes[6] = 8'hba; rbytes[7] = 8'hbe;
        rbytes[8] = 8'h12; rbytes[9] = 8'h34;
        drive(1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 3'd0, 1'b0, 1'b1, rbytes[k], 1'b0);
            step();
        end
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("mid_count", 32'(load_count), 32'h2);
        check("mid_loading", 32'(loading), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_loading", 32'(loading), 32'h0);
        check("arst_count", 32'(load_count), 32'h0);
        check("arst_data", fetch_data, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check("keep_w0_valid", 32'(fetch_valid), 32'h1);
        check("keep_w0", fetch_data, 32'hdeadbeef);
        drive(1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check("keep_w1", fetch_data, 32'hcafebabe);
        drive(1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check("discard_w2", fetch_data, 32'h08090a0b);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check("idle_valid", 32'(fetch_valid), 32'h0);

`ifdef IMEM_PARITY_EN
        // ---- parity: clean word then a flipped stored bit ----
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check("par_clean", 32'(fetch_perr), 32'h0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        dut.mem_r[0][0] = ~dut.mem_r[0][0];
        step();
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check("par_err_valid", 32'(fetch_valid), 32'h1);
        check("par_err", 32'(fetch_perr), 32'h1);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check("par_err_clear", 32'(fetch_perr), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
